// File: rtl/vedic_mul_8bit_pkg.sv
// Shared widths and the 2x2 Vedic cell for the 8x8 Vedic multiplier.
// The 2x2 cell is pure AND gates plus two half adders.
package vedic_mul_8bit_pkg;

    localparam int OP_W   = 8;
    localparam int PR_W   = 16;
    localparam int HALF_W = 4;

    function automatic logic [3:0] vedic2x2(
        input logic [1:0] x,
        input logic [1:0] y
    );
        logic p0, t1, t2, t3;
        logic s1, c1, s2, c2;
        p0 = x[0] & y[0];
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        t3 = x[1] & y[1];
        s1 = t1 ^ t2;
        c1 = t1 & t2;
        s2 = t3 ^ c1;
        c2 = t3 & c1;
        return {c2, s2, s1, p0};
    endfunction

endpackage

// File: rtl/vedic_mul_8bit_mul4.sv
// 4x4 Vedic multiplier built from four 2x2 cells and small adders.
// Purely combinational.
module vedic_mul_4bit
    import vedic_mul_8bit_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    output logic [7:0] p_o
);

    logic [3:0] q_ll, q_lh, q_hl, q_hh;
    logic [4:0] mid;
    logic [3:0] hi;

    assign q_ll = vedic2x2(x_i[1:0], y_i[1:0]);
    assign q_lh = vedic2x2(x_i[1:0], y_i[3:2]);
    assign q_hl = vedic2x2(x_i[3:2], y_i[1:0]);
    assign q_hh = vedic2x2(x_i[3:2], y_i[3:2]);

    // Cross terms plus the upper half of LL; max 3+9+9 fits 5 bits
    assign mid = {3'b000, q_ll[3:2]} + {1'b0, q_lh} + {1'b0, q_hl};
    assign hi  = q_hh + {1'b0, mid[4:2]};

    assign p_o = {hi, mid[1:0], q_ll[1:0]};

endmodule

// File: rtl/vedic_mul_8bit.sv
// 8x8 unsigned Vedic multiplier with a single registered 16-bit product.
// Four 4x4 cells feed a combinational adder tree into the s register.
module vedic_mul_8bit
    import vedic_mul_8bit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [PR_W-1:0] s
);

    logic [7:0]      pp_ll, pp_lh, pp_hl, pp_hh;
    logic [9:0]      mid;
    logic [7:0]      hi;
    logic [PR_W-1:0] s_d, s_q;

    vedic_mul_4bit u_ll (.x_i(a[3:0]), .y_i(b[3:0]), .p_o(pp_ll));
    vedic_mul_4bit u_lh (.x_i(a[3:0]), .y_i(b[7:4]), .p_o(pp_lh));
    vedic_mul_4bit u_hl (.x_i(a[7:4]), .y_i(b[3:0]), .p_o(pp_hl));
    vedic_mul_4bit u_hh (.x_i(a[7:4]), .y_i(b[7:4]), .p_o(pp_hh));

    // Middle column: LL[7:4] + LH + HL, max 465, carries spill into HH
    assign mid = {6'd0, pp_ll[7:4]} + {2'd0, pp_lh} + {2'd0, pp_hl};
    assign hi  = pp_hh + {2'd0, mid[9:4]};

    assign s_d = {hi, mid[3:0], pp_ll[3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_vedic_mul_8bit.sv
// Self-checking bench for vedic_mul_8bit: directed table, random, exhaustive.
// Expected products come from plain integer multiplication.
module tb_vedic_mul_8bit;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] s;

    int nvec;
    int nerr;

    typedef struct {
        logic        rst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[16];

    vedic_mul_8bit dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .s  (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(
        input logic       r,
        input logic [7:0] x,
        input logic [7:0] y
    );
        int unsigned prod;
        prod = int'(x) * int'(y);
        return r ? 16'h0000 : prod[15:0];
    endfunction

    task automatic step(
        input logic        r,
        input logic [7:0]  x,
        input logic [7:0]  y,
        input logic [15:0] exp,
        input string       tag
    );
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
        nvec++;
        if (s !== exp) begin
            nerr++;
            $display("FAIL %s rst=%0b a=%0d b=%0d got=%h want=%h",
                     tag, r, x, y, s, exp);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        a    = 8'h00;
        b    = 8'h00;

        tbl[0]  = '{1'b1, 8'd255, 8'd255, 16'h0000};
        tbl[1]  = '{1'b1, 8'd255, 8'd255, 16'h0000};
        tbl[2]  = '{1'b0, 8'd255, 8'd255, 16'hFE01};
        tbl[3]  = '{1'b0, 8'd15,  8'd15,  16'd225};
        tbl[4]  = '{1'b0, 8'd29,  8'd28,  16'd812};
        tbl[5]  = '{1'b0, 8'd158, 8'd157, 16'd24806};
        tbl[6]  = '{1'b0, 8'd9,   8'd9,   16'd81};
        tbl[7]  = '{1'b0, 8'd0,   8'd200, 16'd0};
        tbl[8]  = '{1'b0, 8'd1,   8'd173, 16'd173};
        tbl[9]  = '{1'b0, 8'd128, 8'd2,   16'd256};
        tbl[10] = '{1'b0, 8'd255, 8'd1,   16'd255};
        tbl[11] = '{1'b0, 8'd200, 8'd0,   16'd0};
        tbl[12] = '{1'b1, 8'd77,  8'd3,   16'd0};
        tbl[13] = '{1'b0, 8'd77,  8'd3,   16'd231};
        tbl[14] = '{1'b0, 8'd16,  8'd16,  16'd256};
        tbl[15] = '{1'b0, 8'd170, 8'd85,  16'd14450};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].exp,
                 $sformatf("table[%0d]", i));
        end

        // Product must hold through the low phase until the next edge
        @(negedge clk);
        nvec++;
        if (s !== 16'd14450) begin
            nerr++;
            $display("FAIL hold got=%h want=%h", s, 16'd14450);
        end

        // Mid-stream reset inside a back-to-back burst
        step(1'b0, 8'd100, 8'd100, 16'd10000, "burst0");
        step(1'b1, 8'd250, 8'd250, 16'd0,     "burst_rst");
        step(1'b0, 8'd250, 8'd250, 16'd62500, "burst_resume");
        step(1'b0, 8'd3,   8'd7,   16'd21,    "burst1");

        for (int i = 0; i < 2000; i++) begin
            logic       r;
            logic [7:0] x, y;
            r = ($urandom_range(0, 31) == 0);
            x = 8'($urandom);
            y = 8'($urandom);
            step(r, x, y, ref_mul(r, x, y), "random");
        end

        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v = 16'(i);
            step(1'b0, v[15:8], v[7:0],
                 ref_mul(1'b0, v[15:8], v[7:0]), "exhaustive");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vedic_mul_8bit.md
VEDIC_MUL_8BIT -- requirements
Module: vedic_mul_8bit

Interface
REQ-001 Parameters SHALL be none: operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a  input  8  unsigned multiplicand.
REQ-005 b  input  8  unsigned multiplier.
REQ-006 s  output  16  unsigned product a*b, registered.

Function
REQ-007 On each rising clk edge with rst low, s SHALL load the full unsigned product of the a and b values sampled at that edge.
REQ-008 Latency SHALL be exactly 1 cycle: s is valid after the first rising edge following the operand change, and holds until the next edge.
REQ-009 Throughput SHALL be one product per cycle; a and b MAY change every cycle, with no handshake and no stall.
REQ-010 The multiply path SHALL be purely combinational between the input pins and the s register, with no intermediate pipeline registers.
REQ-011 Arithmetic SHALL be unsigned and exact over the full 16-bit result, with no truncation, saturation or overflow.
REQ-012 Boundaries: 0*x SHALL give 0; 255*255 SHALL give 0xFE01; 1*x SHALL give x zero-extended.
REQ-013 The product SHALL be built by Vedic (Urdhva-Tiryagbhyam) decomposition:
- split a and b into 4-bit high and low halves;
- form four 4x4 partial products: LL, LH, HL, HH;
- s[3:0] = LL[3:0];
- add LL[7:4], LH and HL into the middle bits;
- combine HH with the middle carries;
- the result SHALL equal a*b bit-exactly.
REQ-014 Each 4x4 product SHALL likewise be built from four 2x2 Vedic products and adders.
REQ-015 Each 2x2 product SHALL be built from AND gates and half adders.
REQ-016 The RTL SHALL NOT use the behavioural * operator.

Reset
REQ-017 While rst is high at a rising clk edge, s SHALL become 16'h0000, regardless of a and b.
REQ-018 On the first rising edge after rst deasserts, s SHALL take a*b of the inputs present at that edge.
REQ-019 Asserting rst mid-stream SHALL discard the pending product; no stale value SHALL appear after reset.
REQ-020 There SHALL be no other state to reset.

Structure
REQ-021 No shared package is needed; widths are local constants (8 and 16).
REQ-022 The natural sub-module SHALL be vedic_mul_4bit (4x4 to 8-bit, combinational).
- It is instantiated four times in vedic_mul_8bit.
- It internally uses a 2x2 Vedic cell and ripple or carry-save adders.
REQ-023 The top level SHALL contain the 8-bit partial-product adder tree plus the 16-bit s register.

Verification
REQ-024 Reset check: hold rst=1 for 2 cycles with a=8'hFF, b=8'hFF -> s=16'h0000; deassert rst -> next edge s=16'hFE01.
REQ-025 Known products, one per cycle, each checked 1 cycle later:
- a=15, b=15 -> s=225 (16'h00E1);
- a=29, b=28 -> s=812 (16'h032C);
- a=158, b=157 -> s=24806 (16'h60E6);
- a=9, b=9 -> s=81 (16'h0051).
REQ-026 Boundaries:
- a=0, b=200 -> s=0;
- a=1, b=173 -> s=173;
- a=128, b=2 -> s=256 (16'h0100);
- a=255, b=1 -> s=255.
REQ-027 Back-to-back: change a and b every cycle; s SHALL track with exactly 1-cycle lag and no bubbles.
REQ-028 Mid-stream reset: assert rst for one edge during a stream -> s=0 that cycle, then the correct product resumes on the next edge.
REQ-029 Exhaustive: all 65,536 (a,b) pairs SHALL be compared against a reference product with a 1-cycle delay, with zero mismatches.
